// File: rtl/nf1g_rbs_master.sv
// nf1g_rbs_master: single-outstanding initiator for the register-bus ring.
// Host transactions are injected as one beat at the ring head and matched on
// return at the ring tail by source tag and word address. All outputs are
// registered; the host-side completion is loaded on entry to DONE.
module nf1g_rbs_master #(
  parameter int C_RBS_ADDR_WIDTH = 32,
  parameter int C_RBS_DATA_WIDTH = 32,
  parameter int C_RBS_SRC_WIDTH  = 2,
  parameter int C_SRC_ID         = 0,
  parameter int C_TIMEOUT        = 1023
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  // host side
  input  logic                          HOST_REQ,
  input  logic                          HOST_RD_WR_L,
  input  logic [C_RBS_ADDR_WIDTH-1:0]   HOST_ADDR,
  input  logic [C_RBS_DATA_WIDTH-1:0]   HOST_WDATA,
  output logic                          HOST_RDY,
  output logic                          HOST_DONE,
  output logic [C_RBS_DATA_WIDTH-1:0]   HOST_RDATA,
  output logic                          HOST_ERR,
  output logic [1:0]                    HOST_ERR_CODE,
  output logic [7:0]                    STALE_CNT,
  // ring head
  output logic                          M_RBS_REQ,
  output logic                          M_RBS_ACK,
  output logic                          M_RBS_RD_WR_L,
  output logic [C_RBS_ADDR_WIDTH-3:0]   M_RBS_ADDR,
  output logic [C_RBS_DATA_WIDTH-1:0]   M_RBS_DATA,
  output logic [C_RBS_SRC_WIDTH-1:0]    M_RBS_SRC,
  // ring tail
  input  logic                          S_RBS_REQ,
  input  logic                          S_RBS_ACK,
  input  logic                          S_RBS_RD_WR_L,
  input  logic [C_RBS_ADDR_WIDTH-3:0]   S_RBS_ADDR,
  input  logic [C_RBS_DATA_WIDTH-1:0]   S_RBS_DATA,
  input  logic [C_RBS_SRC_WIDTH-1:0]    S_RBS_SRC
);

  localparam int SW = C_RBS_SRC_WIDTH;
  localparam int WA = C_RBS_ADDR_WIDTH - 2;
  localparam logic [SW-1:0] SRC_ID = SW'(C_SRC_ID);
  localparam logic [15:0]   TMO    = 16'(C_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    code_d;
  logic [WA-1:0] addr_q;
  logic [15:0]   tmo_cnt;
  logic          match;
  logic          accept;
  logic          stale;
  logic          unused_rd_wr;

  // The returning beat's direction bit carries no information for us.
  assign unused_rd_wr = S_RBS_RD_WR_L;

  // Requests always leave the ring head un-acked; modules set ACK downstream.
  assign M_RBS_ACK = 1'b0;

  assign match  = S_RBS_REQ && (S_RBS_SRC == SRC_ID) && (S_RBS_ADDR == addr_q);
  assign accept = (state_q == IDLE) && (state_d == ISSUE);
  // Anything arriving outside WAIT, or not ours while in WAIT, is dropped.
  assign stale  = S_RBS_REQ && !((state_q == WAIT) && match);

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and the completion code that accompanies entry to DONE.
  // A match on the timeout cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    code_d  = 2'b00;
    case (state_q)
      IDLE: if (HOST_REQ) begin
        if (HOST_ADDR[1:0] != 2'b00) begin
          state_d = DONE;
          code_d  = 2'b11;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: if (match) begin
        state_d = DONE;
        code_d  = S_RBS_ACK ? 2'b00 : 2'b01;
      end else if (tmo_cnt == TMO) begin
        state_d = DONE;
        code_d  = 2'b10;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Host-side status; result fields update only when a completion is loaded.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      HOST_RDY      <= 1'b1;
      HOST_DONE     <= 1'b0;
      HOST_ERR      <= 1'b0;
      HOST_ERR_CODE <= 2'b00;
      HOST_RDATA    <= '0;
    end else begin
      HOST_RDY  <= (state_d == IDLE);
      HOST_DONE <= (state_d == DONE);
      if (state_d == DONE) begin
        HOST_ERR_CODE <= code_d;
        HOST_ERR      <= (code_d != 2'b00);
        HOST_RDATA    <= (code_d == 2'b00) ? S_RBS_DATA : '1;
      end
    end
  end

  // Ring head: one beat during ISSUE, all zero otherwise.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      M_RBS_REQ     <= 1'b0;
      M_RBS_RD_WR_L <= 1'b0;
      M_RBS_ADDR    <= '0;
      M_RBS_DATA    <= '0;
      M_RBS_SRC     <= '0;
    end else begin
      M_RBS_REQ     <= accept;
      M_RBS_RD_WR_L <= accept ? HOST_RD_WR_L : 1'b0;
      M_RBS_ADDR    <= accept ? HOST_ADDR[C_RBS_ADDR_WIDTH-1:2] : '0;
      M_RBS_DATA    <= (accept && !HOST_RD_WR_L) ? HOST_WDATA : '0;
      M_RBS_SRC     <= accept ? SRC_ID : '0;
    end
  end

  // Latched word address for return matching, and the wait counter.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      addr_q  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (accept) addr_q <= HOST_ADDR[C_RBS_ADDR_WIDTH-1:2];
      if (state_q == ISSUE)     tmo_cnt <= '0;
      else if (state_q == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Saturating count of discarded return beats.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)                        STALE_CNT <= '0;
    else if (stale && STALE_CNT != 8'hFF) STALE_CNT <= STALE_CNT + 8'd1;
  end

endmodule

// File: tb/tb_nf1g_rbs_master.sv
// Directed bench for nf1g_rbs_master with C_TIMEOUT=8. The ring tail is
// driven by hand; inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_nf1g_rbs_master;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        HOST_REQ, HOST_RD_WR_L;
  logic [31:0] HOST_ADDR, HOST_WDATA;
  logic        HOST_RDY, HOST_DONE, HOST_ERR;
  logic [31:0] HOST_RDATA;
  logic [1:0]  HOST_ERR_CODE;
  logic [7:0]  STALE_CNT;
  logic        M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L;
  logic [29:0] M_RBS_ADDR;
  logic [31:0] M_RBS_DATA;
  logic [1:0]  M_RBS_SRC;
  logic        S_RBS_REQ, S_RBS_ACK, S_RBS_RD_WR_L;
  logic [29:0] S_RBS_ADDR;
  logic [31:0] S_RBS_DATA;
  logic [1:0]  S_RBS_SRC;

  int tests = 0;
  int fails = 0;

  nf1g_rbs_master #(.C_TIMEOUT(8)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .HOST_REQ(HOST_REQ), .HOST_RD_WR_L(HOST_RD_WR_L), .HOST_ADDR(HOST_ADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_RDY(HOST_RDY), .HOST_DONE(HOST_DONE),
    .HOST_RDATA(HOST_RDATA), .HOST_ERR(HOST_ERR), .HOST_ERR_CODE(HOST_ERR_CODE),
    .STALE_CNT(STALE_CNT),
    .M_RBS_REQ(M_RBS_REQ), .M_RBS_ACK(M_RBS_ACK), .M_RBS_RD_WR_L(M_RBS_RD_WR_L),
    .M_RBS_ADDR(M_RBS_ADDR), .M_RBS_DATA(M_RBS_DATA), .M_RBS_SRC(M_RBS_SRC),
    .S_RBS_REQ(S_RBS_REQ), .S_RBS_ACK(S_RBS_ACK), .S_RBS_RD_WR_L(S_RBS_RD_WR_L),
    .S_RBS_ADDR(S_RBS_ADDR), .S_RBS_DATA(S_RBS_DATA), .S_RBS_SRC(S_RBS_SRC)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a host request for one edge.
  task automatic host(input logic rw, input logic [31:0] a, input logic [31:0] wd);
    HOST_REQ = 1'b1; HOST_RD_WR_L = rw; HOST_ADDR = a; HOST_WDATA = wd;
    tick();
    HOST_REQ = 1'b0;
  endtask

  // Present one beat at the ring tail for one edge.
  task automatic ret(input logic ack, input logic [31:0] d, input logic [29:0] a,
                     input logic [1:0] src);
    S_RBS_REQ = 1'b1; S_RBS_ACK = ack; S_RBS_RD_WR_L = 1'b1;
    S_RBS_ADDR = a; S_RBS_DATA = d; S_RBS_SRC = src;
    tick();
    S_RBS_REQ = 1'b0; S_RBS_ACK = 1'b0; S_RBS_ADDR = '0; S_RBS_DATA = '0; S_RBS_SRC = '0;
  endtask

  task automatic chk_done(input string tag, input logic err, input logic [1:0] code,
                          input logic [31:0] rd);
    chk({tag, ".done"}, HOST_DONE, 1'b1);
    chk({tag, ".err"},  HOST_ERR, err);
    chk({tag, ".code"}, HOST_ERR_CODE, code);
    chk({tag, ".rdata"}, HOST_RDATA, rd);
  endtask

  initial begin
    int beats;
    RESETN = 1'b0;
    HOST_REQ = 0; HOST_RD_WR_L = 0; HOST_ADDR = '0; HOST_WDATA = '0;
    S_RBS_REQ = 0; S_RBS_ACK = 0; S_RBS_RD_WR_L = 0;
    S_RBS_ADDR = '0; S_RBS_DATA = '0; S_RBS_SRC = '0;
    tick(); tick();
    chk("rst.rdy",   HOST_RDY, 1'b1);
    chk("rst.done",  HOST_DONE, 1'b0);
    chk("rst.err",   HOST_ERR, 1'b0);
    chk("rst.code",  HOST_ERR_CODE, 2'b00);
    chk("rst.rdata", HOST_RDATA, 32'h0);
    chk("rst.stale", STALE_CNT, 8'd0);
    chk("rst.mreq",  M_RBS_REQ, 1'b0);
    RESETN = 1'b1;
    tick();

    // Read ok: byte 0x100 -> word 0x40, returns three cycles after issue.
    host(1'b1, 32'h100, 32'h0);
    chk("rd.mreq",  M_RBS_REQ, 1'b1);
    chk("rd.maddr", M_RBS_ADDR, 30'h40);
    chk("rd.msrc",  M_RBS_SRC, 2'd0);
    chk("rd.mack",  M_RBS_ACK, 1'b0);
    chk("rd.mrw",   M_RBS_RD_WR_L, 1'b1);
    chk("rd.mdata", M_RBS_DATA, 32'h0);
    chk("rd.rdy",   HOST_RDY, 1'b0);
    tick();
    chk("rd.mreq1", M_RBS_REQ, 1'b0);
    chk("rd.maddr1", M_RBS_ADDR, 30'h0);
    tick();
    ret(1'b1, 32'h12345678, 30'h40, 2'd0);
    chk_done("rd", 1'b0, 2'b00, 32'h12345678);
    tick();
    chk("rd.done0", HOST_DONE, 1'b0);
    chk("rd.rdy1",  HOST_RDY, 1'b1);
    chk("rd.hold",  HOST_RDATA, 32'h12345678);

    // Write ok: 0x104 -> word 0x41, data echoed back.
    host(1'b0, 32'h104, 32'hCAFEF00D);
    chk("wr.mreq",  M_RBS_REQ, 1'b1);
    chk("wr.mrw",   M_RBS_RD_WR_L, 1'b0);
    chk("wr.maddr", M_RBS_ADDR, 30'h41);
    chk("wr.mdata", M_RBS_DATA, 32'hCAFEF00D);
    tick();
    ret(1'b1, 32'hCAFEF00D, 30'h41, 2'd0);
    chk_done("wr", 1'b0, 2'b00, 32'hCAFEF00D);
    tick();

    // Nack, preceded by a beat with a foreign source tag (stale).
    host(1'b1, 32'h200, 32'h0);
    tick();
    ret(1'b1, 32'h55555555, 30'h80, 2'd1);
    chk("nk.notdone", HOST_DONE, 1'b0);
    chk("nk.stale",   STALE_CNT, 8'd1);
    ret(1'b0, 32'hDEADBEEF, 30'h80, 2'd0);
    chk_done("nk", 1'b1, 2'b01, 32'hFFFFFFFF);
    tick();

    // Timeout: DONE lands 10 cycles after the ring beat.
    host(1'b1, 32'h300, 32'h0);
    chk("to.mreq", M_RBS_REQ, 1'b1);
    repeat (9) tick();
    chk("to.early", HOST_DONE, 1'b0);
    tick();
    chk_done("to", 1'b1, 2'b10, 32'hFFFFFFFF);
    tick();
    ret(1'b1, 32'h1, 30'hC0, 2'd0);
    chk("to.latedone", HOST_DONE, 1'b0);
    chk("to.stale",    STALE_CNT, 8'd2);

    // Misaligned: no ring beat, DONE next cycle with code 11.
    host(1'b1, 32'h102, 32'h0);
    chk("mis.mreq", M_RBS_REQ, 1'b0);
    chk_done("mis", 1'b1, 2'b11, 32'hFFFFFFFF);
    tick();
    chk("mis.rdy", HOST_RDY, 1'b1);

    // Request held high while busy: only one ring beat.
    host(1'b1, 32'h100, 32'h0);
    HOST_REQ = 1'b1;
    beats = int'(M_RBS_REQ);
    for (int i = 0; i < 4; i++) begin
      tick();
      beats += int'(M_RBS_REQ);
    end
    HOST_REQ = 1'b0;
    chk("ign.beats", beats, 1);
    ret(1'b1, 32'h0BADF00D, 30'h40, 2'd0);
    chk_done("ign", 1'b0, 2'b00, 32'h0BADF00D);
    tick();

    // Match on the exact timeout cycle: the match wins.
    host(1'b1, 32'h400, 32'h0);
    repeat (9) tick();
    ret(1'b1, 32'hA5A5A5A5, 30'h100, 2'd0);
    chk_done("sim", 1'b0, 2'b00, 32'hA5A5A5A5);
    tick();

    // Reset during WAIT, then a late return is stale.
    host(1'b1, 32'h500, 32'h0);
    tick();
    RESETN = 1'b0;
    #1;
    chk("mr.rdy",   HOST_RDY, 1'b1);
    chk("mr.done",  HOST_DONE, 1'b0);
    chk("mr.mreq",  M_RBS_REQ, 1'b0);
    chk("mr.rdata", HOST_RDATA, 32'h0);
    chk("mr.stale", STALE_CNT, 8'd0);
    tick();
    RESETN = 1'b1;
    tick();
    ret(1'b1, 32'h77777777, 30'h140, 2'd0);
    chk("mr.latedone", HOST_DONE, 1'b0);
    chk("mr.stale1",   STALE_CNT, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nf1g_rbs_master.md
# nf1g_rbs_master

Register-bus ring initiator for the NetFPGA-1G register pipeline.
- Accepts single read/write transactions from a host-side register interface (PCIe/DMA bridge side).
- Injects each transaction as one request beat at the head of the RBS ring, then waits for it to return from the tail.
- Reports data and status back to the host.
- Sits upstream of the router/switch ports, whose `S_RBS_*`/`M_RBS_*` rings it originates and terminates.

## Interface
Parameters:
- `C_RBS_ADDR_WIDTH`, 32: host byte-address width. The ring carries the word address, `C_RBS_ADDR_WIDTH-2` bits.
- `C_RBS_DATA_WIDTH`, 32: register data width.
- `C_RBS_SRC_WIDTH`, 2: ring source-tag width.
- `C_SRC_ID`, 0: tag this initiator stamps on `M_RBS_SRC` and matches on return.
- `C_TIMEOUT`, 1023: wait cycles before a transaction is declared lost. Must be ≥ 1. The counter is 16 bits wide.

Ports:
- `CLK` in 1: single clock for all logic.
- `RESETN` in 1: reset, asynchronous assert, active-low.
- `HOST_REQ` in 1: transaction request, qualified by `HOST_RDY`.
- `HOST_RD_WR_L` in 1: 1 = read, 0 = write.
- `HOST_ADDR` in `C_RBS_ADDR_WIDTH`: byte address.
- `HOST_WDATA` in `C_RBS_DATA_WIDTH`: write data.
- `HOST_RDY` out 1: high only in IDLE.
- `HOST_DONE` out 1: one-cycle completion pulse.
- `HOST_RDATA` out `C_RBS_DATA_WIDTH`: returned data, valid with `HOST_DONE` and held until the next `HOST_DONE`.
- `HOST_ERR` out 1: error flag, valid with `HOST_DONE`.
- `HOST_ERR_CODE` out 2: error code, valid with `HOST_DONE`.
  - 00 ok.
  - 01 nack (no module claimed the address).
  - 10 timeout.
  - 11 misaligned address.
- `STALE_CNT` out 8: saturating count of discarded return beats.
- `M_RBS_REQ`, `M_RBS_ACK`, `M_RBS_RD_WR_L` out 1: ring head, request beat.
- `M_RBS_ADDR` out `C_RBS_ADDR_WIDTH-2`: ring head address.
- `M_RBS_DATA` out `C_RBS_DATA_WIDTH`: ring head data.
- `M_RBS_SRC` out `C_RBS_SRC_WIDTH`: ring head source tag.
- `S_RBS_REQ`, `S_RBS_ACK`, `S_RBS_RD_WR_L` in 1: ring tail, returning beat.
- `S_RBS_ADDR` in `C_RBS_ADDR_WIDTH-2`: ring tail address.
- `S_RBS_DATA` in `C_RBS_DATA_WIDTH`: ring tail data.
- `S_RBS_SRC` in `C_RBS_SRC_WIDTH`: ring tail source tag.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - `HOST_RDY`=1.
  - `HOST_REQ`=1 with `HOST_ADDR[1:0]`≠0 → DONE with code 11. No ring beat is emitted.
  - `HOST_REQ`=1 with aligned address → latch rd_wr_L, `HOST_ADDR[W-1:2]` and wdata, then go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Drive `M_RBS_REQ`=1, `M_RBS_ACK`=0, `M_RBS_SRC`=`C_SRC_ID`, and the latched rd_wr_L/addr/data.
  - For reads, `M_RBS_DATA` = 0.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - A beat is a match when `S_RBS_REQ`=1, `S_RBS_SRC`=`C_SRC_ID` and `S_RBS_ADDR` = latched address.
  - On a match, capture `S_RBS_DATA`. Code is 00 if `S_RBS_ACK`=1, else 01. Go to DONE.
  - Otherwise the counter increments. When the counter = `C_TIMEOUT`, go to DONE with code 10.
- **DONE** (1 cycle)
  - `HOST_DONE`=1 and `HOST_ERR` = (code≠00).
  - `HOST_RDATA` = captured data for code 00; for writes this is the echoed write data.
  - `HOST_RDATA` = all-ones for codes 01, 10 and 11.
  - Next state is IDLE.
- **Stale beats**
  - Any `S_RBS_REQ`=1 beat in IDLE, ISSUE or DONE, or a non-matching beat in WAIT, is discarded.
  - Each discard increments `STALE_CNT`, which saturates at 255.
- **Idle ring drive**: `M_RBS_*` are all 0 whenever the FSM is not in ISSUE.
- **Simultaneous events**: a match in the same cycle the counter reaches `C_TIMEOUT` → the match wins (code 00/01).
- **Reset mid-operation**: `RESETN` low immediately forces IDLE. A beat returning after reset release is counted as stale.

## Timing
- All outputs are registered.
- Reset values:
  - `HOST_RDY`=1.
  - `HOST_DONE`=0, `HOST_ERR`=0, `HOST_ERR_CODE`=00.
  - `HOST_RDATA`=0.
  - `STALE_CNT`=0.
  - All `M_RBS_*`=0.
- Accept at edge N (IDLE, `HOST_REQ`=1) → `M_RBS_REQ` high in cycle N+1 only.
- Match sampled at edge M → `HOST_DONE` high in cycle M+1.
- Misaligned request at edge N → `HOST_DONE` in cycle N+1.
- Timeout: `HOST_DONE` asserts `C_TIMEOUT`+2 cycles after `M_RBS_REQ`.
- Throughput: at most one outstanding transaction. `HOST_RDY` returns to 1 the cycle after `HOST_DONE`.
- `HOST_REQ` while `HOST_RDY`=0 is ignored, with no queuing.

## Test plan
- **Read ok:** with a 3-cycle ring model that claims 0x40 (ack=1, data=0x12345678), read `HOST_ADDR`=0x100 → one `M_RBS_REQ` beat with addr 0x40, src=0, ack=0, then `HOST_DONE` with `HOST_RDATA`=0x12345678, `HOST_ERR`=0.
- **Write ok:** write 0xCAFEF00D to 0x104 → ring beat with rd_wr_L=0, addr 0x41, data 0xCAFEF00D; return ack=1 → `HOST_DONE`, code 00.
- **Nack:** the beat returns with ack=0 → `HOST_ERR`=1, code 01, `HOST_RDATA`=0xFFFFFFFF.
- **Timeout:** `C_TIMEOUT`=8 with the ring never returning → `HOST_DONE` 10 cycles after `M_RBS_REQ`, code 10. A later return → `STALE_CNT`=1.
- **Misaligned and ignored requests:** `HOST_ADDR`=0x102 → no `M_RBS_REQ`, `HOST_DONE` next cycle with code 11. `HOST_REQ` held while `HOST_RDY`=0 → no second ring beat.
- **Simultaneous events and reset:**
  - A matching return in the exact cycle the timeout is reached → code 00.
  - `RESETN` pulsed low in WAIT → outputs at reset values immediately, `HOST_RDY`=1; the subsequent return is counted as stale.
